// File: rtl/c6ib_wr_scheduler.sv
// -----------------------------------------------------------------------------
// c6ib_wr_scheduler
//
// Sequences one IB-LUT RAM write pass for the CNU6 IB memory. Triples {A,B,C}
// arrive over a valid/ready handshake. Each triple is serialised into three
// write beats to one RAM bank. Banks advance 0..BANK_NUM-1 within a page, and
// pages advance 0..PAGE_NUM-1 within a pass. A single-clock FSM does this work
// in place of the old divide-by-3 clock, port shifter and ram_sel counter.
//
// Ports
//   sys_clk          in   system clock; all logic is on posedge
//   rst              in   synchronous, active-high reset
//   iter_rqst        in   starts a write pass (honoured only in IDLE)
//   iter_termination in   aborts the pass; overrides every other input
//   in_valid         in   the triple on in_portA/B/C is valid
//   in_ready         out  scheduler accepts a triple this cycle (LOAD)
//   in_portA/B/C     in   triple words 0/1/2
//   ram_we           out  one-hot bank write enable
//   ram_wdata        out  write data
//   page_addr        out  page address, common to all banks
//   wr_offset        out  beat within the triple (0=A, 1=B, 2=C)
//   c6ib_rom_rst     out  1-cycle pulse at pass start (INIT)
//   iter_update      out  1-cycle pulse at pass completion (DONE)
//   busy             out  high in every state except IDLE
//   state            out  FSM state code, for debug
//
// Every output is a flop. Each output is loaded from the next-state decode, so
// its value lines up with the state it describes. No input reaches an output
// without passing through a register.
// -----------------------------------------------------------------------------
module c6ib_wr_scheduler #(
  parameter int DATA_W   = 32,
  parameter int BANK_NUM = 4,
  parameter int PAGE_NUM = 32,
  parameter int PAGE_W   = $clog2(PAGE_NUM)
) (
  input  logic                sys_clk,
  input  logic                rst,
  input  logic                iter_rqst,
  input  logic                iter_termination,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_portA,
  input  logic [DATA_W-1:0]   in_portB,
  input  logic [DATA_W-1:0]   in_portC,
  output logic [BANK_NUM-1:0] ram_we,
  output logic [DATA_W-1:0]   ram_wdata,
  output logic [PAGE_W-1:0]   page_addr,
  output logic [1:0]          wr_offset,
  output logic                c6ib_rom_rst,
  output logic                iter_update,
  output logic                busy,
  output logic [2:0]          state
);

  localparam int BANK_W = (BANK_NUM > 1) ? $clog2(BANK_NUM) : 1;
  localparam logic [BANK_W-1:0] BANK_LAST = BANK_W'(BANK_NUM - 1);
  localparam logic [PAGE_W-1:0] PAGE_LAST = PAGE_W'(PAGE_NUM - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_LOAD  = 3'd2,
    ST_SHIFT = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  state_e              state_r, state_fsm_s, state_nxt_s;
  logic [BANK_W-1:0]   bank_r, bank_fsm_s, bank_nxt_s;
  logic [PAGE_W-1:0]   page_r, page_fsm_s, page_nxt_s;
  logic [1:0]          beat_r, beat_fsm_s, beat_nxt_s;
  logic                capture_fsm_s, capture_s;
  logic [DATA_W-1:0]   word_b_r, word_c_r;
  logic [DATA_W-1:0]   wdata_nxt_s;

  logic [BANK_NUM-1:0] ram_we_r;
  logic [DATA_W-1:0]   ram_wdata_r;
  logic [PAGE_W-1:0]   page_addr_r;
  logic [1:0]          wr_offset_r;
  logic                in_ready_r;
  logic                rom_rst_r;
  logic                iter_update_r;
  logic                busy_r;

  // One-hot bank select, written as a loop so that BANK_NUM=1 is still legal.
  function automatic logic [BANK_NUM-1:0] bank_onehot(input logic [BANK_W-1:0] bank);
    logic [BANK_NUM-1:0] oh;
    oh = {BANK_NUM{1'b0}};
    for (int i = 0; i < BANK_NUM; i++) begin
      oh[i] = (bank == BANK_W'(i));
    end
    return oh;
  endfunction

  // Pass sequencing: normal FSM progression, before termination is applied.
  always_comb begin
    state_fsm_s   = state_r;
    bank_fsm_s    = bank_r;
    page_fsm_s    = page_r;
    beat_fsm_s    = beat_r;
    capture_fsm_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (iter_rqst) begin
          state_fsm_s = ST_INIT;
        end else begin
          state_fsm_s = ST_IDLE;
        end
      end
      ST_INIT: begin
        bank_fsm_s  = {BANK_W{1'b0}};
        page_fsm_s  = {PAGE_W{1'b0}};
        beat_fsm_s  = 2'd0;
        state_fsm_s = ST_LOAD;
      end
      ST_LOAD: begin
        if (in_valid) begin
          capture_fsm_s = 1'b1;
          beat_fsm_s    = 2'd0;
          state_fsm_s   = ST_SHIFT;
        end else begin
          state_fsm_s   = ST_LOAD;
        end
      end
      ST_SHIFT: begin
        if (beat_r == 2'd2) begin
          beat_fsm_s = 2'd0;
          if (bank_r != BANK_LAST) begin
            bank_fsm_s  = bank_r + BANK_W'(1'b1);
            state_fsm_s = ST_LOAD;
          end else begin
            bank_fsm_s = {BANK_W{1'b0}};
            if (page_r != PAGE_LAST) begin
              page_fsm_s  = page_r + PAGE_W'(1'b1);
              state_fsm_s = ST_LOAD;
            end else begin
              state_fsm_s = ST_DONE;
            end
          end
        end else begin
          beat_fsm_s = beat_r + 2'd1;
        end
      end
      ST_DONE: begin
        state_fsm_s = ST_IDLE;
      end
      default: begin
        // Illegal codes 5-7 recover to a clean IDLE.
        state_fsm_s = ST_IDLE;
        bank_fsm_s  = {BANK_W{1'b0}};
        page_fsm_s  = {PAGE_W{1'b0}};
        beat_fsm_s  = 2'd0;
      end
    endcase
  end

  // Termination overrides the FSM; in IDLE it also masks a concurrent iter_rqst.
  always_comb begin
    if (iter_termination) begin
      state_nxt_s = ST_IDLE;
      bank_nxt_s  = {BANK_W{1'b0}};
      page_nxt_s  = {PAGE_W{1'b0}};
      beat_nxt_s  = 2'd0;
      capture_s   = 1'b0;
    end else begin
      state_nxt_s = state_fsm_s;
      bank_nxt_s  = bank_fsm_s;
      page_nxt_s  = page_fsm_s;
      beat_nxt_s  = beat_fsm_s;
      capture_s   = capture_fsm_s;
    end
  end

  // Data for the next beat. Beat 0 is loaded straight from port A during the
  // capture edge, so only B and C need holding registers.
  always_comb begin
    case (beat_nxt_s)
      2'd0:    wdata_nxt_s = in_portA;
      2'd1:    wdata_nxt_s = word_b_r;
      2'd2:    wdata_nxt_s = word_c_r;
      default: wdata_nxt_s = word_c_r;
    endcase
  end

  // State, counters, held triple words and all registered outputs.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      bank_r        <= {BANK_W{1'b0}};
      page_r        <= {PAGE_W{1'b0}};
      beat_r        <= 2'd0;
      word_b_r      <= {DATA_W{1'b0}};
      word_c_r      <= {DATA_W{1'b0}};
      ram_we_r      <= {BANK_NUM{1'b0}};
      ram_wdata_r   <= {DATA_W{1'b0}};
      page_addr_r   <= {PAGE_W{1'b0}};
      wr_offset_r   <= 2'd0;
      in_ready_r    <= 1'b0;
      rom_rst_r     <= 1'b0;
      iter_update_r <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      bank_r        <= bank_nxt_s;
      page_r        <= page_nxt_s;
      beat_r        <= beat_nxt_s;
      if (capture_s) begin
        word_b_r <= in_portB;
        word_c_r <= in_portC;
      end else begin
        word_b_r <= word_b_r;
        word_c_r <= word_c_r;
      end
      in_ready_r    <= (state_nxt_s == ST_LOAD);
      rom_rst_r     <= (state_nxt_s == ST_INIT);
      iter_update_r <= (state_nxt_s == ST_DONE);
      busy_r        <= (state_nxt_s != ST_IDLE);
      // Address and data hold their last values outside SHIFT.
      if (state_nxt_s == ST_SHIFT) begin
        ram_we_r    <= bank_onehot(bank_nxt_s);
        ram_wdata_r <= wdata_nxt_s;
        page_addr_r <= page_nxt_s;
        wr_offset_r <= beat_nxt_s;
      end else begin
        ram_we_r    <= {BANK_NUM{1'b0}};
        ram_wdata_r <= ram_wdata_r;
        page_addr_r <= page_addr_r;
        wr_offset_r <= wr_offset_r;
      end
    end
  end

  assign in_ready     = in_ready_r;
  assign ram_we       = ram_we_r;
  assign ram_wdata    = ram_wdata_r;
  assign page_addr    = page_addr_r;
  assign wr_offset    = wr_offset_r;
  assign c6ib_rom_rst = rom_rst_r;
  assign iter_update  = iter_update_r;
  assign busy         = busy_r;
  assign state        = state_r;

endmodule
